mem_lsu: RTL

- Memory-access stage, directly downstream of the EX/MEM pipeline register.
- Consumes the registered issue-slot-1 memory fields: aluop, mem_addr, reg2, wdata, exception_type, LLbit.
- Decodes load/store type, checks alignment, and runs one data-cache transaction over a valid/ready request + response handshake.
- Extends load data, resolves SC, and stalls the pipeline until the access completes. Its outputs feed the MEM/WB register.

---
 rtl/mem_lsu_pkg.sv | 81 ++++++++
 rtl/mem_lsu_align.sv | 43 ++++
 rtl/mem_lsu.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage.
// Memory aluop codes, exception bit positions, FSM states, decoder.
package mem_lsu_pkg;

    localparam logic [7:0] OP_LB  = 8'he0;
    localparam logic [7:0] OP_LH  = 8'he1;
    localparam logic [7:0] OP_LW  = 8'he3;
    localparam logic [7:0] OP_LBU = 8'he4;
    localparam logic [7:0] OP_LHU = 8'he5;
    localparam logic [7:0] OP_SB  = 8'he8;
    localparam logic [7:0] OP_SH  = 8'he9;
    localparam logic [7:0] OP_SW  = 8'heb;
    localparam logic [7:0] OP_LL  = 8'hf0;
    localparam logic [7:0] OP_SC  = 8'hf8;

    localparam int EXC_ADEL = 4;
    localparam int EXC_ADES = 5;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RESP = 2'd1,
        S_DONE      = 2'd2,
        S_DRAIN     = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } lsu_size_e;

    typedef struct packed {
        logic      load;
        logic      store;
        logic      sc;
        lsu_size_e size;
    } lsu_dec_t;

    function automatic lsu_dec_t lsu_decode(input logic [7:0] op);
        lsu_dec_t d;
        d.load  = 1'b0;
        d.store = 1'b0;
        d.sc    = 1'b0;
        d.size  = SZ_NONE;
        case (op)
            OP_LB, OP_LBU: begin
                d.load = 1'b1;
                d.size = SZ_BYTE;
            end
            OP_LH, OP_LHU: begin
                d.load = 1'b1;
                d.size = SZ_HALF;
            end
            OP_LW, OP_LL: begin
                d.load = 1'b1;
                d.size = SZ_WORD;
            end
            OP_SB: begin
                d.store = 1'b1;
                d.size  = SZ_BYTE;
            end
            OP_SH: begin
                d.store = 1'b1;
                d.size  = SZ_HALF;
            end
            OP_SW: begin
                d.store = 1'b1;
                d.size  = SZ_WORD;
            end
            OP_SC: begin
                d.store = 1'b1;
                d.sc    = 1'b1;
                d.size  = SZ_WORD;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for stores and load extraction/extension.
// Purely combinational; little-endian lanes.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = load_raw[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? load_raw[31:16] : load_raw[15:0];

    always_comb begin
        wstrb      = 4'b0000;
        wdata_lane = store_data;
        load_data  = load_raw;
        case (aluop)
            OP_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU: load_data = {24'b0, ld_byte};
            OP_LH:  load_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU: load_data = {16'b0, ld_half};
            OP_SB: begin
                wstrb      = 4'b0001 << off;
                wdata_lane = {4{store_data[7:0]}};
            end
            OP_SH: begin
                wstrb      = off[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{store_data[15:0]}};
            end
            OP_SW, OP_SC: wstrb = 4'b1111;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: decode, alignment check, one cache
// transaction per instruction, and stall until it completes.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_hold_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [31:0]       exception_type_i,
    input  logic              llbit_i,
    output logic              dc_req_valid_o,
    input  logic              dc_req_ready_i,
    output logic [ADDR_W-1:0] dc_req_addr_o,
    output logic [3:0]        dc_req_wstrb_o,
    output logic [DATA_W-1:0] dc_req_wdata_o,
    input  logic              dc_resp_valid_i,
    input  logic [DATA_W-1:0] dc_resp_rdata_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [31:0]       exception_type_o,
    output logic [31:0]       badvaddr_o,
    output logic              stallreq_o
);

    lsu_dec_t    dec;
    lsu_state_e  state_q, state_d;
    logic [31:0] rdata_q;
    logic        misal, go, req_v, stall;
    logic [3:0]  strb;
    logic [31:0] lane_wdata, ld_data, res, exc_add;

    assign dec   = lsu_decode(aluop_i);
    assign misal = (dec.size == SZ_HALF && mem_addr_i[0])
                || (dec.size == SZ_WORD && mem_addr_i[1:0] != 2'b00);

    // Only an aligned, exception-free op (and a live SC) touches the cache.
    assign go = (dec.load || dec.store) && !misal
             && (exception_type_i == 32'b0)
             && !(dec.sc && !llbit_i);

    mem_lsu_align u_align (
        .aluop      (aluop_i),
        .off        (mem_addr_i[1:0]),
        .store_data (reg2_i),
        .load_raw   (rdata_q),
        .wstrb      (strb),
        .wdata_lane (lane_wdata),
        .load_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT_RESP && dc_resp_valid_i && !flush)
                rdata_q <= dc_resp_rdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        req_v   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go && !flush) begin
                    req_v = 1'b1;
                    stall = 1'b1;
                    if (dc_req_ready_i)
                        state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                stall = 1'b1;
                if (flush)
                    state_d = dc_resp_valid_i ? S_IDLE : S_DRAIN;
                else if (dc_resp_valid_i)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (flush || !mem_hold_i)
                    state_d = S_IDLE;
            end
            S_DRAIN: begin
                stall = go;
                if (dc_resp_valid_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res = wdata_i;
        if (dec.load || dec.store) begin
            res = 32'b0;
            if (state_q == S_DONE) begin
                if (dec.load)
                    res = ld_data;
                else if (dec.sc)
                    res = 32'd1;
            end
        end
    end

    always_comb begin
        exc_add           = 32'b0;
        exc_add[EXC_ADEL] = misal && dec.load;
        exc_add[EXC_ADES] = misal && dec.store;
    end

    // Outputs are forced low while reset is held, mid-transaction too.
    assign dc_req_valid_o   = rst && req_v;
    assign dc_req_addr_o    = dc_req_valid_o
                            ? {mem_addr_i[ADDR_W-1:2], 2'b00} : '0;
    assign dc_req_wstrb_o   = dc_req_valid_o ? strb : 4'b0;
    assign dc_req_wdata_o   = dc_req_valid_o ? lane_wdata : '0;
    assign stallreq_o       = rst && stall;
    assign wdata_o          = rst ? res : '0;
    assign exception_type_o = rst ? (exception_type_i | exc_add) : 32'b0;
    assign badvaddr_o       = (rst && misal) ? mem_addr_i : 32'b0;

endmodule
